valu_elem_sequencer: RTL and testbench

- Sequences one multi-element (vector) ALU operation through a single shared scalar ALU, one element per cycle.
- Sits between vector decode/issue and the vector register-file writeback stage.
- The ALU is external to this block. The block drives the ALU's op/inA/inB inputs and samples its out/overflow outputs combinationally in the same cycle.
- Handles vl, masking, vector-scalar (vx) forms and tail/mask-undisturbed merging. Returns the full destination vector with a valid/ready handshake.

---
 rtl/valu_elem_sequencer_pkg.sv | 41 ++++
 rtl/valu_elem_sequencer_if.sv | 60 ++++++
 rtl/valu_elem_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_valu_elem_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/valu_elem_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// valu_elem_sequencer_pkg
// Shared definitions for the vector element sequencer:
//   - vseq_state_e : sequencer FSM state encodings (IDLE/RUN/DONE)
//   - ALU_*        : scalar ALU opcode encodings driven on alu_op
//   - vl_clamp     : limits a requested vector length to the hardware maximum
// Optional feature macro used by the sequencer: VALU_SEQ_OVF_EN
// -----------------------------------------------------------------------------
package valu_elem_sequencer_pkg;

    typedef enum logic [1:0] {
        VSEQ_IDLE = 2'd0,
        VSEQ_RUN  = 2'd1,
        VSEQ_DONE = 2'd2
    } vseq_state_e;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLL   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_SLT   = 4'd8;
    localparam logic [3:0] ALU_SLTU  = 4'd9;
    localparam logic [3:0] ALU_LUI   = 4'd10;
    localparam logic [3:0] ALU_AUIPC = 4'd11;
    localparam logic [3:0] ALU_PASS  = 4'd12;
    localparam logic [3:0] ALU_SUBU  = 4'd13;

    // Effective element count: requests longer than the hardware holds are cut.
    function automatic int unsigned vl_clamp(input int unsigned vl, input int unsigned max_vl);
        if (vl > max_vl) begin
            vl_clamp = max_vl;
        end else begin
            vl_clamp = vl;
        end
    endfunction

endpackage

// File: rtl/valu_elem_sequencer_if.sv
// -----------------------------------------------------------------------------
// valu_elem_sequencer_if
// Bundles the three buses of the vector element sequencer:
//   request  : req_valid/req_ready handshake plus op, vl, vx, vm, mask,
//              vs2, vs1, rs1 and vd_old operands
//   response : resp_valid/resp_ready handshake plus resp_vd
//   ALU      : alu_op/alu_inA/alu_inB towards the shared scalar ALU and
//              alu_out/alu_overflow back from it (combinational, same cycle)
// Modports:
//   slave  - the sequencer itself
//   master - the environment (issue stage, writeback consumer and ALU)
// -----------------------------------------------------------------------------
interface valu_elem_sequencer_if #(
    parameter int N      = 32,
    parameter int MAX_VL = 8,
    parameter int VL_W   = $clog2(MAX_VL) + 1
);
    logic                  req_valid;
    logic                  req_ready;
    logic [3:0]            req_op;
    logic [VL_W-1:0]       req_vl;
    logic                  req_vx;
    logic                  req_vm;
    logic [MAX_VL-1:0]     req_mask;
    logic [MAX_VL*N-1:0]   req_vs2;
    logic [MAX_VL*N-1:0]   req_vs1;
    logic [N-1:0]          req_rs1;
    logic [MAX_VL*N-1:0]   req_vd_old;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [MAX_VL*N-1:0]   resp_vd;

    logic [3:0]            alu_op;
    logic [N-1:0]          alu_inA;
    logic [N-1:0]          alu_inB;
    logic [N-1:0]          alu_out;
    logic                  alu_overflow;

    modport slave (
        input  req_valid, req_op, req_vl, req_vx, req_vm, req_mask,
               req_vs2, req_vs1, req_rs1, req_vd_old,
        output req_ready,
        output resp_valid, resp_vd,
        input  resp_ready,
        output alu_op, alu_inA, alu_inB,
        input  alu_out, alu_overflow
    );

    modport master (
        output req_valid, req_op, req_vl, req_vx, req_vm, req_mask,
               req_vs2, req_vs1, req_rs1, req_vd_old,
        input  req_ready,
        input  resp_valid, resp_vd,
        output resp_ready,
        input  alu_op, alu_inA, alu_inB,
        output alu_out, alu_overflow
    );

endinterface

// File: rtl/valu_elem_sequencer.sv
// -----------------------------------------------------------------------------
// valu_elem_sequencer
// Runs one vector ALU operation through a single external scalar ALU, one
// element per clock, and returns the merged destination vector.
//   clk      : single clock, rising edge
//   rst_n    : asynchronous active-low reset
//   flush    : synchronous abort, returns to IDLE and drops the result
//   bus      : request / response / ALU buses (valu_elem_sequencer_if.slave)
//   busy     : high while a request is in RUN or DONE
//   resp_ovf : per-element overflow flags (only with VALU_SEQ_OVF_EN)
// Optional feature macro: VALU_SEQ_OVF_EN
// Masked-off elements and tail elements (idx >= vl) keep their vd_old value.
// All outputs, including the ALU operands, come straight from flops; the
// operands for element idx+1 are loaded on the edge that retires element idx.
// -----------------------------------------------------------------------------
module valu_elem_sequencer
    import valu_elem_sequencer_pkg::*;
#(
    parameter int N      = 32,
    parameter int MAX_VL = 8,
    parameter int VL_W   = $clog2(MAX_VL) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    valu_elem_sequencer_if.slave  bus,
`ifdef VALU_SEQ_OVF_EN
    output logic [MAX_VL-1:0]     resp_ovf,
`endif
    output logic                  busy
);

    localparam int IDX_W = $clog2(MAX_VL);
    localparam int VEC_W = MAX_VL * N;

    vseq_state_e         state_r;
    vseq_state_e         state_next_s;
    logic [IDX_W-1:0]    idx_r;
    logic [VL_W-1:0]     vl_eff_r;
    logic [3:0]          op_r;
    logic                vx_r;
    logic                vm_r;
    logic [MAX_VL-1:0]   mask_r;
    logic [VEC_W-1:0]    vs2_r;
    logic [VEC_W-1:0]    vs1_r;
    logic [N-1:0]        rs1_r;
    logic [VEC_W-1:0]    resp_vd_r;
    logic                req_ready_r;
    logic                resp_valid_r;
    logic                busy_r;
    logic [3:0]          alu_op_r;
    logic [N-1:0]        alu_a_r;
    logic [N-1:0]        alu_b_r;

    logic                accept_s;
    logic                last_s;
    logic                wr_en_s;
    logic [VL_W-1:0]     req_vl_eff_s;
    logic [IDX_W-1:0]    idx_nxt_s;
    logic [N-1:0]        a_nxt_s;
    logic [N-1:0]        b_nxt_s;

`ifdef VALU_SEQ_OVF_EN
    logic [MAX_VL-1:0]   ovf_r;
`else
    logic                unused_ovf_s;
    assign unused_ovf_s = bus.alu_overflow;
`endif

    // Next state, accept/write/last strobes and the next element's operands
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        last_s       = 1'b0;
        wr_en_s      = 1'b0;
        req_vl_eff_s = VL_W'(vl_clamp(32'(bus.req_vl), 32'(MAX_VL)));
        idx_nxt_s    = idx_r + IDX_W'(1);
        a_nxt_s      = vs2_r[idx_nxt_s*N +: N];
        if (vx_r) begin
            b_nxt_s = rs1_r;
        end else begin
            b_nxt_s = vs1_r[idx_nxt_s*N +: N];
        end

        if (flush) begin
            state_next_s = VSEQ_IDLE;
        end else begin
            case (state_r)
                VSEQ_IDLE: begin
                    if (bus.req_valid) begin
                        accept_s = 1'b1;
                        if (req_vl_eff_s == VL_W'(0)) begin
                            state_next_s = VSEQ_DONE;
                        end else begin
                            state_next_s = VSEQ_RUN;
                        end
                    end else begin
                        state_next_s = VSEQ_IDLE;
                    end
                end
                VSEQ_RUN: begin
                    wr_en_s = vm_r | mask_r[idx_r];
                    if (VL_W'(idx_r) == (vl_eff_r - VL_W'(1))) begin
                        last_s       = 1'b1;
                        state_next_s = VSEQ_DONE;
                    end else begin
                        state_next_s = VSEQ_RUN;
                    end
                end
                VSEQ_DONE: begin
                    if (bus.resp_ready) begin
                        state_next_s = VSEQ_IDLE;
                    end else begin
                        state_next_s = VSEQ_DONE;
                    end
                end
                default: begin
                    state_next_s = VSEQ_IDLE;
                end
            endcase
        end
    end

    // State register, request capture, element merge and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= VSEQ_IDLE;
            idx_r        <= '0;
            vl_eff_r     <= '0;
            op_r         <= 4'd0;
            vx_r         <= 1'b0;
            vm_r         <= 1'b0;
            mask_r       <= '0;
            vs2_r        <= '0;
            vs1_r        <= '0;
            rs1_r        <= '0;
            resp_vd_r    <= '0;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            alu_op_r     <= 4'd0;
            alu_a_r      <= '0;
            alu_b_r      <= '0;
`ifdef VALU_SEQ_OVF_EN
            ovf_r        <= '0;
`endif
        end else begin
            state_r      <= state_next_s;
            req_ready_r  <= (state_next_s == VSEQ_IDLE);
            resp_valid_r <= (state_next_s == VSEQ_DONE);
            busy_r       <= (state_next_s != VSEQ_IDLE);

            if (flush) begin
                idx_r    <= '0;
                alu_op_r <= 4'd0;
                alu_a_r  <= '0;
                alu_b_r  <= '0;
`ifdef VALU_SEQ_OVF_EN
                ovf_r    <= '0;
`endif
            end else if (accept_s) begin
                idx_r     <= '0;
                vl_eff_r  <= req_vl_eff_s;
                op_r      <= bus.req_op;
                vx_r      <= bus.req_vx;
                vm_r      <= bus.req_vm;
                mask_r    <= bus.req_mask;
                vs2_r     <= bus.req_vs2;
                vs1_r     <= bus.req_vs1;
                rs1_r     <= bus.req_rs1;
                resp_vd_r <= bus.req_vd_old;
`ifdef VALU_SEQ_OVF_EN
                ovf_r     <= '0;
`endif
                // Preload element 0 so the ALU sees it in the first RUN cycle.
                if (req_vl_eff_s != VL_W'(0)) begin
                    alu_op_r <= bus.req_op;
                    alu_a_r  <= bus.req_vs2[N-1:0];
                    alu_b_r  <= bus.req_vx ? bus.req_rs1 : bus.req_vs1[N-1:0];
                end else begin
                    alu_op_r <= 4'd0;
                    alu_a_r  <= '0;
                    alu_b_r  <= '0;
                end
            end else if (state_r == VSEQ_RUN) begin
                if (wr_en_s) begin
                    resp_vd_r[idx_r*N +: N] <= bus.alu_out;
`ifdef VALU_SEQ_OVF_EN
                    ovf_r[idx_r] <= bus.alu_overflow;
`endif
                end
                // Quiet the shared ALU once the last element retires.
                if (last_s) begin
                    alu_op_r <= 4'd0;
                    alu_a_r  <= '0;
                    alu_b_r  <= '0;
                end else begin
                    idx_r    <= idx_nxt_s;
                    alu_op_r <= op_r;
                    alu_a_r  <= a_nxt_s;
                    alu_b_r  <= b_nxt_s;
                end
            end
        end
    end

    assign bus.req_ready  = req_ready_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_vd    = resp_vd_r;
    assign bus.alu_op     = alu_op_r;
    assign bus.alu_inA    = alu_a_r;
    assign bus.alu_inB    = alu_b_r;
    assign busy           = busy_r;
`ifdef VALU_SEQ_OVF_EN
    assign resp_ovf       = ovf_r;
`endif

endmodule

// File: tb/tb_valu_elem_sequencer.sv
// -----------------------------------------------------------------------------
// tb_valu_elem_sequencer
// Directed bench for valu_elem_sequencer: a table of vector requests with
// hand-computed results and latencies, plus hand-written sequences for
// backpressure, flush, asynchronous reset and (with VALU_SEQ_OVF_EN) overflow.
// The bench models the external scalar ALU combinationally.
// -----------------------------------------------------------------------------
module tb_valu_elem_sequencer;
    import valu_elem_sequencer_pkg::*;

    localparam int N      = 32;
    localparam int MAX_VL = 8;
    localparam int VL_W   = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic busy;
`ifdef VALU_SEQ_OVF_EN
    logic [MAX_VL-1:0] resp_ovf;
`endif

    int n_checks = 0;
    int n_errors = 0;

    valu_elem_sequencer_if #(.N(N), .MAX_VL(MAX_VL), .VL_W(VL_W)) bus ();

    valu_elem_sequencer #(.N(N), .MAX_VL(MAX_VL), .VL_W(VL_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .bus      (bus.slave),
`ifdef VALU_SEQ_OVF_EN
        .resp_ovf (resp_ovf),
`endif
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Scalar ALU model
    logic [31:0] alu_sum;
    assign alu_sum = bus.alu_inA + bus.alu_inB;
    always_comb begin
        bus.alu_out      = 32'd0;
        bus.alu_overflow = 1'b0;
        case (bus.alu_op)
            ALU_ADD: begin
                bus.alu_out      = alu_sum;
                bus.alu_overflow = (bus.alu_inA[31] == bus.alu_inB[31]) && (alu_sum[31] != bus.alu_inA[31]);
            end
            ALU_SUB:  bus.alu_out = bus.alu_inA - bus.alu_inB;
            ALU_XOR:  bus.alu_out = bus.alu_inA ^ bus.alu_inB;
            ALU_PASS: bus.alu_out = bus.alu_inB;
            default:  bus.alu_out = 32'd0;
        endcase
    end

    typedef struct {
        string        name;
        logic [3:0]   op;
        logic [3:0]   vl;
        logic         vx;
        logic         vm;
        logic [7:0]   mask;
        logic [255:0] vs2;
        logic [255:0] vs1;
        logic [31:0]  rs1;
        logic [255:0] vd_old;
        logic [255:0] exp_vd;
        int           exp_lat;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_req(input vec_t v);
        bus.req_op     = v.op;
        bus.req_vl     = v.vl;
        bus.req_vx     = v.vx;
        bus.req_vm     = v.vm;
        bus.req_mask   = v.mask;
        bus.req_vs2    = v.vs2;
        bus.req_vs1    = v.vs1;
        bus.req_rs1    = v.rs1;
        bus.req_vd_old = v.vd_old;
        bus.req_valid  = 1'b1;
    endtask

    // Counts edges from the accept edge until resp_valid, bounded.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (bus.resp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (bus.resp_valid !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL resp_valid_timeout: got 0 expected 1");
        end
    endtask

    task automatic handshake();
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        int bad;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        chk({v.name, "_ready"}, 256'(bus.req_ready), 256'(1));
        drive_req(v);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 1;
        bad = 0;
        while (bus.resp_valid !== 1'b1 && lat < 40) begin
            if (lat <= MAX_VL) begin
                exp_a = v.vs2[(lat-1)*32 +: 32];
                exp_b = v.vx ? v.rs1 : v.vs1[(lat-1)*32 +: 32];
            end else begin
                exp_a = 32'd0;
                exp_b = 32'd0;
            end
            if (bus.alu_op !== v.op || bus.alu_inA !== exp_a || bus.alu_inB !== exp_b) bad++;
            @(posedge clk); #1;
            lat++;
        end
        chk({v.name, "_latency"}, 256'(lat), 256'(v.exp_lat));
        chk({v.name, "_operands_bad_cycles"}, 256'(bad), 256'(0));
        chk({v.name, "_resp_vd"}, bus.resp_vd, v.exp_vd);
        chk({v.name, "_alu_quiet"}, {bus.alu_op, bus.alu_inA, bus.alu_inB}, 256'(0));
        handshake();
        chk({v.name, "_after_hs"}, {bus.req_ready, bus.resp_valid, busy}, 256'(3'b100));
    endtask

    function automatic logic [255:0] rep(input logic [31:0] x);
        return {8{x}};
    endfunction

    initial begin
        vec_t v;
        int   lat;
        int   seen;
        logic [255:0] hold_vd;

        vecs[0] = '{"vv_add", ALU_ADD, 4'd4, 1'b0, 1'b1, 8'h00,
                    {128'd0, 32'd4, 32'd3, 32'd2, 32'd1},
                    {128'd0, 32'd40, 32'd30, 32'd20, 32'd10},
                    32'd0, rep(32'h0000DEAD),
                    {{4{32'h0000DEAD}}, 32'd44, 32'd33, 32'd22, 32'd11}, 5};
        vecs[1] = '{"vx_sub", ALU_SUB, 4'd8, 1'b1, 1'b1, 8'h00,
                    rep(32'd3), rep(32'h99), 32'd5, rep(32'd0),
                    rep(32'hFFFFFFFE), 9};
        vecs[2] = '{"masked_add", ALU_ADD, 4'd4, 1'b0, 1'b0, 8'b0000_0101,
                    {128'd0, 32'd4, 32'd3, 32'd2, 32'd1},
                    {128'd0, 32'd400, 32'd300, 32'd200, 32'd100},
                    32'd0, rep(32'h77),
                    {{5{32'h77}}, 32'd303, 32'h77, 32'd101}, 5};
        vecs[3] = '{"vl_zero", ALU_ADD, 4'd0, 1'b0, 1'b1, 8'h00,
                    rep(32'd1), rep(32'd1), 32'd0, rep(32'h12345678),
                    rep(32'h12345678), 1};
        vecs[4] = '{"vl_clamp", ALU_ADD, 4'd15, 1'b0, 1'b1, 8'h00,
                    rep(32'd1),
                    {32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0},
                    32'd0, rep(32'hAAAA),
                    {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1}, 9};
        vecs[5] = '{"xor_tail", ALU_XOR, 4'd3, 1'b0, 1'b0, 8'b1111_1010,
                    rep(32'hF0F0F0F0), rep(32'h0FF00FF0), 32'd0, rep(32'h5A5A5A5A),
                    {{6{32'h5A5A5A5A}}, 32'hFF00FF00, 32'h5A5A5A5A}, 4};

        bus.req_valid  = 1'b0;
        bus.req_op     = 4'd0;
        bus.req_vl     = 4'd0;
        bus.req_vx     = 1'b0;
        bus.req_vm     = 1'b0;
        bus.req_mask   = 8'd0;
        bus.req_vs2    = 256'd0;
        bus.req_vs1    = 256'd0;
        bus.req_rs1    = 32'd0;
        bus.req_vd_old = 256'd0;
        bus.resp_ready = 1'b0;

        // Reset state
        #12;
        chk("reset_ctrl", {bus.req_ready, bus.resp_valid, busy}, 256'(3'b100));
        chk("reset_vd", bus.resp_vd, 256'd0);
        chk("reset_alu", {bus.alu_op, bus.alu_inA, bus.alu_inB}, 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end

        // Backpressure: DONE held 3 cycles while another request waits
        v = '{"bp", ALU_ADD, 4'd2, 1'b0, 1'b1, 8'h00, rep(32'd5), rep(32'd6), 32'd0,
              rep(32'd0), {{6{32'd0}}, 32'd11, 32'd11}, 3};
        drive_req(v);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        wait_valid(lat);
        hold_vd = bus.resp_vd;
        chk("bp_vd", hold_vd, v.exp_vd);
        v = '{"bp2", ALU_ADD, 4'd1, 1'b0, 1'b1, 8'h00, rep(32'd1), rep(32'd1), 32'd0,
              rep(32'd9), {{7{32'd9}}, 32'd2}, 2};
        drive_req(v);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("bp_hold_vd", bus.resp_vd, hold_vd);
            chk("bp_hold_ctrl", {bus.req_ready, bus.resp_valid}, 256'(2'b01));
        end
        handshake();
        chk("bp_no_bypass", {bus.req_ready, busy}, 256'(2'b10));
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("bp_accept_next", {bus.req_ready, busy}, 256'(2'b01));
        wait_valid(lat);
        chk("bp2_vd", bus.resp_vd, v.exp_vd);
        handshake();

        // Flush at idx=2
        v = '{"fl", ALU_ADD, 4'd8, 1'b0, 1'b1, 8'h00,
              {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1},
              rep(32'd0), 32'd0, rep(32'd0), rep(32'd0), 9};
        drive_req(v);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        chk("flush_at_idx2", 256'(bus.alu_inA), 256'(32'd3));
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_ctrl", {bus.req_ready, bus.resp_valid, busy}, 256'(3'b100));
        chk("flush_alu", {bus.alu_op, bus.alu_inA, bus.alu_inB}, 256'd0);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (bus.resp_valid === 1'b1) seen++;
        end
        chk("flush_no_resp", 256'(seen), 256'(0));

        // Flush beats a same-cycle request
        drive_req(vecs[0]);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        bus.req_valid = 1'b0;
        chk("flush_blocks_accept", {bus.req_ready, busy}, 256'(2'b10));

        // Asynchronous reset in the middle of RUN
        drive_req(vecs[1]);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #3;
        chk("pre_reset_busy", 256'(busy), 256'(1));
        rst_n = 1'b0;
        #1;
        chk("rst_run_ctrl", {bus.req_ready, bus.resp_valid, busy}, 256'(3'b100));
        chk("rst_run_vd", bus.resp_vd, 256'd0);
        chk("rst_run_alu", {bus.alu_op, bus.alu_inA, bus.alu_inB}, 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

`ifdef VALU_SEQ_OVF_EN
        v = '{"ovf", ALU_ADD, 4'd2, 1'b0, 1'b1, 8'h00,
              {{6{32'd0}}, 32'h7FFFFFFF, 32'd1}, rep(32'd1), 32'd0, rep(32'd0),
              {{6{32'd0}}, 32'h80000000, 32'd2}, 3};
        drive_req(v);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        wait_valid(lat);
        chk("ovf_vd", bus.resp_vd, v.exp_vd);
        chk("ovf_bits", 256'(resp_ovf), 256'(8'b0000_0010));
        handshake();
        drive_req(vecs[3]);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("ovf_clear_on_accept", 256'(resp_ovf), 256'(0));
        wait_valid(lat);
        handshake();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time bound
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
